// File: rtl/eb_pack.sv
// eb_pack: packs RATIO upstream beats of DWIDTH bits into one wide word for a
// downstream elastic stage. Lane 0 holds the first beat of a word. t_last
// closes a word early, and the unused upper lanes are then zero.
// Optional feature: define EB_PACK_KEEP_EN to add the i_keep lane-valid mask.
module eb_pack #(
    parameter int DWIDTH = 8,
    parameter int RATIO  = 4
) (
    input  logic                    clk,
    input  logic                    rstf,
    input  logic [DWIDTH-1:0]       t_data,
    input  logic                    t_valid,
    input  logic                    t_last,
    output logic                    t_ready,
    output logic [DWIDTH*RATIO-1:0] i_data,
    output logic                    i_valid,
    output logic                    i_last,
    input  logic                    i_ready
`ifdef EB_PACK_KEEP_EN
    ,
    output logic [RATIO-1:0]        i_keep
`endif
);

    localparam int CW = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int WW = DWIDTH * RATIO;
    localparam logic [CW-1:0] CNT_MAX = CW'(RATIO - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [WW-1:0] staged_w, word_w, data_q, data_d;
    logic          valid_q, valid_d, last_q, last_d;
    logic          accept_w, xfer_w, complete_w;

    assign t_ready    = i_ready | ~valid_q;
    assign accept_w   = t_valid & t_ready;
    assign xfer_w     = valid_q & i_ready;
    assign complete_w = t_last | (cnt_q == CNT_MAX);

    // Staging only needs RATIO-1 lanes: the final beat goes straight to the
    // output register. With RATIO=1 there is nothing to stage.
    generate
        if (RATIO > 1) begin : g_stage
            logic [(RATIO-1)*DWIDTH-1:0] stage_q, stage_d;

            // Next staging content: capture the lane on a partial accept,
            // clear it when the word completes.
            always_comb begin
                stage_d = stage_q;
                if (accept_w) begin
                    stage_d = complete_w ? '0 : word_w[(RATIO-1)*DWIDTH-1:0];
                end
            end

            // Staging register.
            always_ff @(posedge clk or negedge rstf) begin
                if (!rstf) stage_q <= '0;
                else       stage_q <= stage_d;
            end

            assign staged_w = {{DWIDTH{1'b0}}, stage_q};
        end else begin : g_nostage
            assign staged_w = '0;
        end
    endgenerate

    // Candidate word: staged lanes with the current beat dropped into lane cnt.
    // Lanes above cnt are already zero because staging is cleared per word.
    always_comb begin
        word_w = staged_w;
        word_w[int'(cnt_q)*DWIDTH +: DWIDTH] = t_data;
    end

`ifdef EB_PACK_KEEP_EN
    logic [RATIO-1:0] keep_q, keep_d, keep_w;

    // Lanes 0..cnt are filled by the word that completes now.
    always_comb begin
        keep_w = '0;
        for (int k = 0; k < RATIO; k++) begin
            keep_w[k] = (k <= int'(cnt_q));
        end
    end

    assign i_keep = keep_q;
`endif

    // Output stage and lane counter next-state; a completing accept wins over
    // a word transfer so the stage can refill with no bubble.
    always_comb begin
        cnt_d   = cnt_q;
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
`ifdef EB_PACK_KEEP_EN
        keep_d  = keep_q;
`endif
        if (xfer_w) valid_d = 1'b0;
        if (accept_w) begin
            if (complete_w) begin
                cnt_d   = '0;
                valid_d = 1'b1;
                data_d  = word_w;
                last_d  = t_last;
`ifdef EB_PACK_KEEP_EN
                keep_d  = keep_w;
`endif
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Output and counter registers; reset drops any partial word.
    always_ff @(posedge clk or negedge rstf) begin
        if (!rstf) begin
            cnt_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
`ifdef EB_PACK_KEEP_EN
            keep_q  <= '0;
`endif
        end else begin
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
`ifdef EB_PACK_KEEP_EN
            keep_q  <= keep_d;
`endif
        end
    end

    assign i_data  = data_q;
    assign i_valid = valid_q;
    assign i_last  = last_q;

endmodule

// File: tb/tb_eb_pack.sv
// Bench for eb_pack: a RATIO=4 instance driven by directed packets against an
// expected-word queue, plus a RATIO=1 instance for the single-register case.
module tb_eb_pack;

    logic        clk = 1'b0;
    logic        rstf;
    logic [7:0]  t_data;
    logic        t_valid, t_last, t_ready;
    logic [31:0] i_data;
    logic        i_valid, i_last, i_ready;

    logic [7:0]  r1_t_data;
    logic        r1_t_valid, r1_t_last, r1_t_ready;
    logic [7:0]  r1_i_data;
    logic        r1_i_valid, r1_i_last, r1_i_ready;

`ifdef EB_PACK_KEEP_EN
    logic [3:0]  i_keep;
    logic [0:0]  r1_i_keep;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int nwords = 0;
    int stalls = 0;

    logic [32:0] exp_q[$];
    logic [31:0] m_word;
    int          m_cnt;

    eb_pack #(.DWIDTH(8), .RATIO(4)) u_dut (
        .clk(clk), .rstf(rstf),
        .t_data(t_data), .t_valid(t_valid), .t_last(t_last), .t_ready(t_ready),
        .i_data(i_data), .i_valid(i_valid), .i_last(i_last), .i_ready(i_ready)
`ifdef EB_PACK_KEEP_EN
        , .i_keep(i_keep)
`endif
    );

    eb_pack #(.DWIDTH(8), .RATIO(1)) u_dut1 (
        .clk(clk), .rstf(rstf),
        .t_data(r1_t_data), .t_valid(r1_t_valid), .t_last(r1_t_last), .t_ready(r1_t_ready),
        .i_data(r1_i_data), .i_valid(r1_i_valid), .i_last(r1_i_last), .i_ready(r1_i_ready)
`ifdef EB_PACK_KEEP_EN
        , .i_keep(r1_i_keep)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Scoreboard side: every word leaving the RATIO=4 instance is popped here.
    always @(negedge clk) begin
        if (rstf === 1'b1 && i_valid === 1'b1 && i_ready === 1'b1) begin
            nwords++;
            if (exp_q.size() == 0) begin
                check("unexpected_word", {31'd0, i_last, i_data}, 64'hDEAD);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                check("word_data", {32'd0, i_data}, {32'd0, e[31:0]});
                check("word_last", {63'd0, i_last}, {63'd0, e[32]});
            end
        end
    end

    // Drive one beat and hold it until accepted; the packing model pushes the
    // expected word when this beat closes it.
    task automatic beat(input logic [7:0] d, input logic l);
        bit done = 0;
        t_valid = 1'b1;
        t_data  = d;
        t_last  = l;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (t_ready === 1'b1) begin
                done = 1;
                m_word[m_cnt*8 +: 8] = d;
                if (l || m_cnt == 3) begin
                    exp_q.push_back({l, m_word});
                    m_word = '0;
                    m_cnt  = 0;
                end else begin
                    m_cnt++;
                end
            end else begin
                stalls++;
            end
            @(posedge clk);
            #1;
        end
        if (!done) check("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic idle();
        t_valid = 1'b0;
        t_data  = 8'hEE;
        t_last  = 1'b1;
    endtask

    initial begin
        int c0, w0, s0;
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int c0, w0, s0;
        m_word = '0;
        m_cnt  = 0;
        rstf = 1'b0;
        idle();
        i_ready = 1'b1;
        r1_t_valid = 1'b0; r1_t_data = 8'h00; r1_t_last = 1'b0; r1_i_ready = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_valid", {63'd0, i_valid}, 64'd0);
        check("rst_last",  {63'd0, i_last}, 64'd0);
        check("rst_data",  {32'd0, i_data}, 64'd0);
        check("rst_tready", {63'd0, t_ready}, 64'd1);
        check("rst_r1_tready", {63'd0, r1_t_ready}, 64'd1);
        rstf = 1'b1;
        @(negedge clk);
        check("post_rst_tready", {63'd0, t_ready}, 64'd1);
        @(posedge clk); #1;

        // Full packing.
        beat(8'h11, 1'b0); beat(8'h22, 1'b0); beat(8'h33, 1'b0); beat(8'h44, 1'b1);
        idle();
        @(negedge clk);
        check("full_valid", {63'd0, i_valid}, 64'd1);
        check("full_data", {32'd0, i_data}, 64'h44332211);
        check("full_last", {63'd0, i_last}, 64'd1);
`ifdef EB_PACK_KEEP_EN
        check("full_keep", {60'd0, i_keep}, 64'hF);
`endif
        @(posedge clk); #1;

        // Early last, then the next packet must start in lane 0.
        beat(8'hAA, 1'b0); beat(8'hBB, 1'b1);
        idle();
        @(negedge clk);
        check("early_data", {32'd0, i_data}, 64'h0000BBAA);
        check("early_last", {63'd0, i_last}, 64'd1);
`ifdef EB_PACK_KEEP_EN
        check("early_keep", {60'd0, i_keep}, 64'h3);
`endif
        @(posedge clk); #1;
        beat(8'hCC, 1'b1);
        idle();
        @(negedge clk);
        check("lane0_data", {32'd0, i_data}, 64'h000000CC);
        @(posedge clk); #1;

        // Backpressure: word pending with i_ready low for 5 cycles.
        i_ready = 1'b0;
        @(negedge clk);
        check("bp_drained", {63'd0, i_valid}, 64'd0);
        @(posedge clk); #1;
        beat(8'hD1, 1'b0); beat(8'hD2, 1'b0); beat(8'hD3, 1'b0); beat(8'hD4, 1'b0);
        idle();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", {63'd0, i_valid}, 64'd1);
            check("bp_data", {32'd0, i_data}, 64'hD4D3D2D1);
            check("bp_last", {63'd0, i_last}, 64'd0);
            check("bp_tready", {63'd0, t_ready}, 64'd0);
        end
        @(posedge clk); #1;
        i_ready = 1'b1;
        @(negedge clk);
        check("bp_release_tready", {63'd0, t_ready}, 64'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_after_valid", {63'd0, i_valid}, 64'd0);
        @(posedge clk); #1;

        // Back-to-back: 8 beats in 8 cycles, two words, no stalls.
        c0 = cyc; w0 = nwords; s0 = stalls;
        for (int i = 0; i < 8; i++) beat(8'(8'h30 + i), 1'b0);
        check("b2b_cycles", 64'(cyc - c0), 64'd8);
        idle();
        repeat (2) @(negedge clk);
        check("b2b_words", 64'(nwords - w0), 64'd2);
        check("b2b_stalls", 64'(stalls - s0), 64'd0);
        @(posedge clk); #1;

        // Reset mid-packet discards the partial word.
        beat(8'hE1, 1'b0); beat(8'hE2, 1'b0);
        idle();
        #2 rstf = 1'b0;
        m_word = '0;
        m_cnt  = 0;
        @(negedge clk);
        check("midrst_valid", {63'd0, i_valid}, 64'd0);
        check("midrst_data", {32'd0, i_data}, 64'd0);
        check("midrst_tready", {63'd0, t_ready}, 64'd1);
        rstf = 1'b1;
        @(posedge clk); #1;
        beat(8'h01, 1'b0); beat(8'h02, 1'b0); beat(8'h03, 1'b0); beat(8'h04, 1'b0);
        idle();
        @(negedge clk);
        check("midrst_word", {32'd0, i_data}, 64'h04030201);
        check("midrst_word_last", {63'd0, i_last}, 64'd0);
        @(posedge clk); #1;

        // RATIO=1: single register stage.
        r1_t_valid = 1'b1; r1_t_data = 8'h5A; r1_t_last = 1'b0; r1_i_ready = 1'b0;
        @(negedge clk);
        check("r1_tready_empty", {63'd0, r1_t_ready}, 64'd1);
        @(posedge clk); #1;
        r1_t_valid = 1'b0; r1_t_data = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("r1_hold_valid", {63'd0, r1_i_valid}, 64'd1);
            check("r1_hold_data", {56'd0, r1_i_data}, 64'h5A);
            check("r1_hold_tready", {63'd0, r1_t_ready}, 64'd0);
`ifdef EB_PACK_KEEP_EN
            check("r1_keep", {63'd0, r1_i_keep}, 64'd1);
`endif
        end
        @(posedge clk); #1;
        r1_i_ready = 1'b1;
        @(negedge clk);
        check("r1_release_tready", {63'd0, r1_t_ready}, 64'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("r1_after_valid", {63'd0, r1_i_valid}, 64'd0);

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
